rpn_stack_sequencer: RTL and testbench

Parametrised sequencer between the front-panel inputs (switches, push/operation/clear buttons), the operand stack memory and the ALU of the stack calculator. Pushes switch values, executes binary operations (pop B, pop A, push result), and clears the stack. It tracks stack occupancy internally, so it can refuse overflow and underflow. Each accepted command is latched and runs to completion regardless of button changes, then waits for all buttons to be released.

---
 rtl/rpn_stack_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rpn_stack_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_sequencer.sv
// rpn_stack_sequencer: front-panel command sequencer for the RPN stack calculator.
// Drives push/pop strobes into the operand stack, feeds the ALU and tracks
// stack occupancy so overflow and underflow are refused rather than issued.
//
// state | meaning
// ------+--------------------------------------------------------------------
// IDLE  | waiting for exactly one button; operand B is latched on leaving IDLE
// WB    | B pop in flight, drop pop and let the stack memory settle
// LATA  | new top valid: latch operand A and pop it
// WA    | A pop in flight, drop pop and arm the ALU latency counter
// ALU   | wait for the ALU result, then push it
// CLR   | pop one entry per cycle until the stack is empty
// HOLD  | command done, wait for every button to be released
module rpn_stack_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SW_W    = 16,
  parameter int DEPTH   = 16,
  parameter int NUM_OPS = 4,
  parameter int ALU_LAT = 1,
  localparam int OP_W   = $clog2(NUM_OPS),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   switches,
  input  logic              btn_push,
  input  logic [NUM_OPS-1:0] btn_op,
  input  logic              btn_clr,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] alu_out,
  output logic              push,
  output logic              pop,
  output logic [DATA_W-1:0] mem_in,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [CNT_W-1:0]  depth,
  output logic              busy,
  output logic              err_under,
  output logic              err_over
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, WB, LATA, WA, ALU, CLR, HOLD
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [OP_W-1:0]  op_idx;
  logic             one_press;
  logic             any_btn;
  logic             full;
  logic             lt_two;

  // Decode the one-hot operation buttons into a binary index
  always_comb begin
    op_idx = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (btn_op[i]) op_idx = OP_W'(i);
    end
  end

  assign one_press = ($countones({btn_push, btn_op, btn_clr}) == 1);
  assign any_btn   = btn_push | (|btn_op) | btn_clr;
  assign full      = (depth == CNT_W'(DEPTH));
  // Written as two equalities so it stays correct even when CNT_W is 1 bit
  assign lt_two    = (depth == '0) || (depth == CNT_W'(1));
  assign busy      = (state != IDLE) && (state != HOLD);

  // Command sequencer: all strobes, operands and occupancy are registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      push      <= 1'b0;
      pop       <= 1'b0;
      mem_in    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      depth     <= '0;
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          push <= 1'b0;
          pop  <= 1'b0;
          if (one_press) begin
            err_under <= 1'b0;
            err_over  <= 1'b0;
            if (btn_push) begin
              if (full) begin
                err_over <= 1'b1;
              end else begin
                mem_in <= DATA_W'(switches);
                push   <= 1'b1;
                depth  <= depth + CNT_W'(1);
              end
              state <= HOLD;
            end else if (btn_clr) begin
              // First pop goes out with the acceptance edge so N entries take N cycles
              if (depth != '0) begin
                pop   <= 1'b1;
                depth <= depth - CNT_W'(1);
              end
              state <= CLR;
            end else begin
              if (lt_two) begin
                err_under <= 1'b1;
                state     <= HOLD;
              end else begin
                alu_op <= op_idx;
                alu_b  <= mem_out;
                pop    <= 1'b1;
                depth  <= depth - CNT_W'(1);
                state  <= WB;
              end
            end
          end
        end
        WB: begin
          pop   <= 1'b0;
          state <= LATA;
        end
        LATA: begin
          alu_a <= mem_out;
          pop   <= 1'b1;
          depth <= depth - CNT_W'(1);
          state <= WA;
        end
        WA: begin
          pop     <= 1'b0;
          lat_cnt <= LAT_W'(ALU_LAT - 1);
          state   <= ALU;
        end
        ALU: begin
          if (lat_cnt == '0) begin
            mem_in <= alu_out;
            push   <= 1'b1;
            depth  <= depth + CNT_W'(1);
            state  <= HOLD;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        CLR: begin
          if (depth != '0) begin
            pop   <= 1'b1;
            depth <= depth - CNT_W'(1);
          end else begin
            pop   <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          push <= 1'b0;
          pop  <= 1'b0;
          if (!any_btn) state <= IDLE;
        end
        default: begin
          push  <= 1'b0;
          pop   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer with a behavioural stack memory and ALU.
module tb_rpn_stack_sequencer;

  localparam int DATA_W  = 32;
  localparam int SW_W    = 16;
  localparam int DEPTH   = 4;
  localparam int NUM_OPS = 4;
  localparam int ALU_LAT = 1;
  localparam int OP_W    = 2;
  localparam int CNT_W   = 3;

  logic               clk;
  logic               rst;
  logic [SW_W-1:0]    switches;
  logic               btn_push;
  logic [NUM_OPS-1:0] btn_op;
  logic               btn_clr;
  logic [DATA_W-1:0]  mem_out;
  logic [DATA_W-1:0]  alu_out;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  mem_in;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [OP_W-1:0]    alu_op;
  logic [CNT_W-1:0]   depth;
  logic               busy;
  logic               err_under;
  logic               err_over;

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int p0;
  int q0;

  rpn_stack_sequencer #(
    .DATA_W(DATA_W), .SW_W(SW_W), .DEPTH(DEPTH), .NUM_OPS(NUM_OPS), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst(rst), .switches(switches), .btn_push(btn_push), .btn_op(btn_op),
    .btn_clr(btn_clr), .mem_out(mem_out), .alu_out(alu_out), .push(push), .pop(pop),
    .mem_in(mem_in), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .depth(depth),
    .busy(busy), .err_under(err_under), .err_over(err_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack memory: top entry visible on mem_out
  logic [DATA_W-1:0] stk [0:DEPTH-1];
  int sp;

  always @(posedge clk or negedge rst) begin
    if (!rst) sp <= 0;
    else if (push && sp < DEPTH) sp <= sp + 1;
    else if (pop && sp > 0) sp <= sp - 1;
  end

  always @(posedge clk) begin
    if (rst && push && sp < DEPTH) stk[sp] <= mem_in;
  end

  assign mem_out = (sp > 0) ? stk[sp-1] : '0;

  // Model ALU: add, sub, and, or
  always_comb begin
    case (alu_op)
      2'd0:    alu_out = alu_a + alu_b;
      2'd1:    alu_out = alu_a - alu_b;
      2'd2:    alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  // Strobe counters used to prove single execution
  always @(posedge clk) begin
    if (push) push_cnt <= push_cnt + 1;
    if (pop)  pop_cnt  <= pop_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_push(input logic [SW_W-1:0] val, input int exp_depth);
    switches = val;
    btn_push = 1'b1;
    tick(1);
    chk("push_strobe", 64'(push), 64'd1);
    chk("push_data", 64'(mem_in), 64'(val));
    chk("push_depth", 64'(depth), 64'(exp_depth));
    chk("push_no_pop", 64'(pop), 64'd0);
    tick(1);
    chk("push_pulse_end", 64'(push), 64'd0);
    btn_push = 1'b0;
    tick(2);
  endtask

  initial begin
    rst      = 1'b0;
    switches = '0;
    btn_push = 1'b0;
    btn_op   = '0;
    btn_clr  = 1'b0;
    tick(2);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_in", 64'(mem_in), 64'd0);
    chk("rst_errs", 64'({err_under, err_over}), 64'd0);
    rst = 1'b1;
    tick(1);

    // Two pushes: stack [5,3]
    do_push(16'h0005, 1);
    do_push(16'h0003, 2);
    chk("push_no_err", 64'({err_under, err_over}), 64'd0);

    // Add, button held 20 cycles
    p0 = push_cnt;
    q0 = pop_cnt;
    btn_op = 4'b0001;
    tick(1);
    chk("op_b", 64'(alu_b), 64'd3);
    chk("op_pop_b", 64'(pop), 64'd1);
    chk("op_depth_b", 64'(depth), 64'd1);
    chk("op_busy", 64'(busy), 64'd1);
    tick(1);
    chk("op_pop_b_end", 64'(pop), 64'd0);
    tick(1);
    chk("op_a", 64'(alu_a), 64'd5);
    chk("op_pop_a", 64'(pop), 64'd1);
    chk("op_depth_a", 64'(depth), 64'd0);
    tick(1);
    chk("op_pop_a_end", 64'(pop), 64'd0);
    chk("op_no_early_push", 64'(push), 64'd0);
    tick(1);
    chk("op_push", 64'(push), 64'd1);
    chk("op_result", 64'(mem_in), 64'd8);
    chk("op_index", 64'(alu_op), 64'd0);
    chk("op_depth_r", 64'(depth), 64'd1);
    tick(1);
    chk("op_push_end", 64'(push), 64'd0);
    tick(14);
    chk("op_single_push", 64'(push_cnt - p0), 64'd1);
    chk("op_single_pops", 64'(pop_cnt - q0), 64'd2);
    btn_op = '0;
    tick(2);

    // Underflow with one entry
    p0 = push_cnt;
    q0 = pop_cnt;
    btn_op = 4'b0001;
    tick(1);
    chk("under_flag", 64'(err_under), 64'd1);
    chk("under_depth", 64'(depth), 64'd1);
    tick(2);
    chk("under_no_strobes", 64'((push_cnt - p0) + (pop_cnt - q0)), 64'd0);
    btn_op = '0;
    tick(2);
    do_push(16'h0002, 2);
    chk("under_cleared", 64'(err_under), 64'd0);

    // Subtract with op buttons changed mid-sequence: stack [8,2] -> 6
    btn_op = 4'b0010;
    tick(1);
    chk("chg_b", 64'(alu_b), 64'd2);
    tick(1);
    btn_op = 4'b0100;
    tick(3);
    chk("chg_push", 64'(push), 64'd1);
    chk("chg_result", 64'(mem_in), 64'd6);
    chk("chg_index", 64'(alu_op), 64'd1);
    chk("chg_depth", 64'(depth), 64'd1);
    btn_op = '0;
    tick(2);

    // Two buttons at once: ignored
    p0 = push_cnt;
    q0 = pop_cnt;
    btn_push = 1'b1;
    btn_op   = 4'b0010;
    tick(5);
    chk("multi_busy", 64'(busy), 64'd0);
    chk("multi_depth", 64'(depth), 64'd1);
    chk("multi_no_strobes", 64'((push_cnt - p0) + (pop_cnt - q0)), 64'd0);
    btn_push = 1'b0;
    btn_op   = '0;
    tick(2);

    // Fill to DEPTH, then overflow
    do_push(16'h0001, 2);
    do_push(16'h0002, 3);
    do_push(16'h0003, 4);
    p0 = push_cnt;
    switches = 16'h0009;
    btn_push = 1'b1;
    tick(1);
    chk("over_flag", 64'(err_over), 64'd1);
    chk("over_no_push", 64'(push), 64'd0);
    chk("over_depth", 64'(depth), 64'd4);
    tick(1);
    chk("over_push_cnt", 64'(push_cnt - p0), 64'd0);
    btn_push = 1'b0;
    tick(2);

    // Clear four entries: pop held exactly four consecutive cycles
    q0 = pop_cnt;
    btn_clr = 1'b1;
    tick(1);
    chk("clr_err_cleared", 64'(err_over), 64'd0);
    chk("clr_pop_0", 64'(pop), 64'd1);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk("clr_pop_run", 64'(pop), 64'd1);
    end
    tick(1);
    chk("clr_pop_end", 64'(pop), 64'd0);
    chk("clr_depth", 64'(depth), 64'd0);
    tick(3);
    chk("clr_pop_count", 64'(pop_cnt - q0), 64'd4);
    btn_clr = 1'b0;
    tick(2);

    // Clear on an empty stack: no pop
    q0 = pop_cnt;
    btn_clr = 1'b1;
    tick(4);
    chk("clr_empty_pops", 64'(pop_cnt - q0), 64'd0);
    chk("clr_empty_busy", 64'(busy), 64'd0);
    btn_clr = 1'b0;
    tick(2);

    // Async reset while waiting in ALU
    do_push(16'h0004, 1);
    do_push(16'h0007, 2);
    btn_op = 4'b0001;
    tick(4);
    chk("arst_pre_busy", 64'(busy), 64'd1);
    chk("arst_pre_a", 64'(alu_a), 64'd4);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_push", 64'(push), 64'd0);
    chk("arst_pop", 64'(pop), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_depth", 64'(depth), 64'd0);
    chk("arst_alu_a", 64'(alu_a), 64'd0);
    chk("arst_alu_b", 64'(alu_b), 64'd0);
    chk("arst_mem_in", 64'(mem_in), 64'd0);
    btn_op = '0;
    tick(1);
    rst = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
